// File: rtl/and_chain_pkg.sv
// Shared types and the round-robin pick helper for the AndChain lane scheduler.
package and_chain_pkg;

    localparam int AC_MAX_LANES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lane_state_t;

    typedef logic [2:0] abc_t;
    typedef logic [2:0] def_t;
    typedef logic [2:0] lane_idx_t;

    // Bits of mask above the configured lane count must be 0, so a mod-8 scan
    // visits the live lanes in the same order as a mod-N_LANES scan.
    function automatic lane_idx_t rr_pick(input logic [AC_MAX_LANES-1:0] mask,
                                          input lane_idx_t ptr);
        lane_idx_t idx;
        lane_idx_t pick;
        logic      found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < AC_MAX_LANES; k++) begin
            idx = ptr + lane_idx_t'(k);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/and_chain_lane_ctrl.sv
// One scheduled lane: IDLE -> BUSY (drive abc for LAT cycles) -> DONE (hold d/e/f) -> IDLE.
module and_chain_lane_ctrl
    import and_chain_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    input  abc_t             abc_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             release_i,
    input  def_t             def_i,
    output lane_state_t      state_o,
    output abc_t             drive_o,
    output logic [TAG_W-1:0] tag_o,
    output def_t             def_o
);

    localparam int              CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    lane_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    abc_t             abc_q, abc_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    def_t             def_q, def_d;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        tag_d   = tag_q;
        def_d   = def_q;
        case (state_q)
            IDLE: begin
                if (issue_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    abc_d   = abc_i;
                    tag_d   = tag_i;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    def_d   = def_i;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (release_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every lane register updates from the same pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            abc_q   <= '0;
            tag_q   <= '0;
            def_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            tag_q   <= tag_d;
            def_q   <= def_d;
        end
    end

    assign state_o = state_q;
    assign drive_o = (state_q == BUSY) ? abc_q : '0;
    assign tag_o   = tag_q;
    assign def_o   = def_q;

endmodule

// File: rtl/and_chain_lane_sched.sv
// Round-robin scheduler sharing N_LANES AndChain lanes among one request stream.
// Optional statistics counters are enabled by defining AND_CHAIN_SCHED_STATS_EN.
module and_chain_lane_sched
    import and_chain_pkg::*;
#(
    parameter int N_LANES = 5,
    parameter int LAT     = 2,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_abc,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_def,
    output logic [TAG_W-1:0]   out_tag,
    output logic [2:0]         out_lane,
    output logic [N_LANES-1:0] lane_a,
    output logic [N_LANES-1:0] lane_b,
    output logic [N_LANES-1:0] lane_c,
    input  logic [N_LANES-1:0] lane_d,
    input  logic [N_LANES-1:0] lane_e,
    input  logic [N_LANES-1:0] lane_f
`ifdef AND_CHAIN_SCHED_STATS_EN
    ,
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_stall
`endif
);

    lane_state_t      lane_st  [N_LANES];
    abc_t             lane_drv [N_LANES];
    logic [TAG_W-1:0] lane_tag [N_LANES];
    def_t             lane_def [N_LANES];

    logic [N_LANES-1:0]      lane_issue, lane_rel;
    logic [AC_MAX_LANES-1:0] idle_mask, done_mask;
    lane_idx_t               issue_ptr_q, issue_ptr_d, out_ptr_q, out_ptr_d;
    lane_idx_t               lock_lane_q, lock_lane_d, issue_lane, out_sel;
    logic                    lock_q, lock_d, in_fire, out_fire;

    function automatic lane_idx_t next_idx(input lane_idx_t i);
        return (i == lane_idx_t'(N_LANES - 1)) ? '0 : i + lane_idx_t'(1);
    endfunction

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        and_chain_lane_ctrl #(.LAT(LAT), .TAG_W(TAG_W)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .issue_i   (lane_issue[g]),
            .abc_i     (in_abc),
            .tag_i     (in_tag),
            .release_i (lane_rel[g]),
            .def_i     ({lane_d[g], lane_e[g], lane_f[g]}),
            .state_o   (lane_st[g]),
            .drive_o   (lane_drv[g]),
            .tag_o     (lane_tag[g]),
            .def_o     (lane_def[g])
        );
    end

    always_comb begin
        idle_mask = '0;
        done_mask = '0;
        lane_a    = '0;
        lane_b    = '0;
        lane_c    = '0;
        for (int i = 0; i < N_LANES; i++) begin
            idle_mask[i] = (lane_st[i] == IDLE);
            done_mask[i] = (lane_st[i] == DONE);
            lane_a[i]    = lane_drv[i][2];
            lane_b[i]    = lane_drv[i][1];
            lane_c[i]    = lane_drv[i][0];
        end
    end

    // A lane freed by this cycle's result accept is still DONE here, so it cannot be reissued yet.
    assign in_ready   = !rst && (|idle_mask);
    assign out_valid  = |done_mask;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign issue_lane = rr_pick(idle_mask, issue_ptr_q);
    assign out_sel    = lock_q ? lock_lane_q : rr_pick(done_mask, out_ptr_q);

    always_comb begin
        out_def    = '0;
        out_tag    = '0;
        out_lane   = '0;
        lane_issue = '0;
        lane_rel   = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (out_valid && (out_sel == lane_idx_t'(i))) begin
                out_def  = lane_def[i];
                out_tag  = lane_tag[i];
                out_lane = out_sel;
            end
            lane_issue[i] = in_fire && (issue_lane == lane_idx_t'(i));
            lane_rel[i]   = out_fire && (out_sel == lane_idx_t'(i));
        end
    end

    always_comb begin
        issue_ptr_d = issue_ptr_q;
        out_ptr_d   = out_ptr_q;
        lock_d      = lock_q;
        lock_lane_d = lock_lane_q;
        if (in_fire) begin
            issue_ptr_d = next_idx(issue_lane);
        end
        if (out_fire) begin
            lock_d    = 1'b0;
            out_ptr_d = next_idx(out_sel);
        end else if (out_valid) begin
            lock_d      = 1'b1;
            lock_lane_d = out_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_ptr_q <= '0;
            out_ptr_q   <= '0;
            lock_q      <= 1'b0;
            lock_lane_q <= '0;
        end else begin
            issue_ptr_q <= issue_ptr_d;
            out_ptr_q   <= out_ptr_d;
            lock_q      <= lock_d;
            lock_lane_q <= lock_lane_d;
        end
    end

`ifdef AND_CHAIN_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (in_fire) begin
                stat_issued_q <= stat_issued_q + 32'd1;
            end
            if (in_valid && !in_ready) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule
